// File: rtl/ppu_issue_ctrl.sv
// Issue/collect sequencer between EX and the PPU lanes: one broadcast pulse per op,
// per-lane result capture with timeout (NaR fill), flush, and a wrapping done counter.
module ppu_issue_ctrl #(
  parameter int PPU_NUM = 2,
  parameter int LANE_W  = 32 / PPU_NUM,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        op_a_i,
  input  logic [31:0]        op_b_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               flush_i,
  output logic               ppu_valid_o,
  output logic [31:0]        ppu_in1_o,
  output logic [31:0]        ppu_in2_o,
  output logic [OP_W-1:0]    ppu_op_o,
  input  logic [PPU_NUM-1:0] lane_valid_i,
  input  logic [31:0]        lane_out_i,
  output logic [31:0]        result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic               error_o,
  output logic               busy_o,
  output logic [15:0]        op_count_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q;
  logic [PPU_NUM-1:0]  mask_q;
  logic [7:0]          timer_q;
  logic [31:0]         in1_q, in2_q, res_q;
  logic [OP_W-1:0]     op_q;
  logic                ppu_vld_q, res_vld_q, err_q;
  logic [15:0]         cnt_q;

  logic [PPU_NUM-1:0]  mask_d;
  logic [31:0]         res_d, res_nar;
  logic                all_done, timed_out;

  // mask_q is always zero on entry to ISSUE, so the same capture logic serves ISSUE and WAIT.
  always_comb begin
    mask_d  = mask_q | lane_valid_i;
    res_d   = res_q;
    for (int i = 0; i < PPU_NUM; i++) begin
      if (lane_valid_i[i] && !mask_q[i]) res_d[LANE_W*i +: LANE_W] = lane_out_i[LANE_W*i +: LANE_W];
    end
    res_nar = res_d;
    for (int i = 0; i < PPU_NUM; i++) begin
      if (!mask_d[i]) res_nar[LANE_W*i +: LANE_W] = {1'b1, {(LANE_W-1){1'b0}}};
    end
    all_done  = &mask_d;
    timed_out = (timer_q == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      timer_q   <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      op_q      <= '0;
      res_q     <= '0;
      ppu_vld_q <= 1'b0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      timer_q   <= '0;
      ppu_vld_q <= 1'b0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          in1_q     <= op_a_i;
          in2_q     <= op_b_i;
          op_q      <= op_i;
          res_q     <= '0;
          mask_q    <= '0;
          timer_q   <= '0;
          ppu_vld_q <= 1'b1;
          state_q   <= ISSUE;
        end
        ISSUE: begin
          ppu_vld_q <= 1'b0;
          timer_q   <= '0;
          mask_q    <= mask_d;
          res_q     <= res_d;
          if (all_done) begin
            res_vld_q <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= DONE;
          end else begin
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          mask_q <= mask_d;
          if (all_done) begin
            res_q     <= res_d;
            res_vld_q <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= DONE;
          end else if (timed_out) begin
            res_q     <= res_nar;
            res_vld_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= DONE;
          end else begin
            res_q     <= res_d;
            timer_q   <= timer_q + 8'd1;
          end
        end
        DONE: if (result_ready_i) begin
          cnt_q     <= cnt_q + 16'd1;
          res_vld_q <= 1'b0;
          err_q     <= 1'b0;
          mask_q    <= '0;
          timer_q   <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = (state_q == IDLE) & ~flush_i;
  assign busy_o         = (state_q != IDLE);
  assign ppu_valid_o    = ppu_vld_q;
  assign ppu_in1_o      = in1_q;
  assign ppu_in2_o      = in2_q;
  assign ppu_op_o       = op_q;
  assign result_o       = res_q;
  assign result_valid_o = res_vld_q;
  assign error_o        = err_q;
  assign op_count_o     = cnt_q;

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Bench for ppu_issue_ctrl: transaction-level model checked every cycle, plus literal checks.
module tb_ppu_issue_ctrl;
  localparam int N  = 2;
  localparam int TO = 63;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, flush, result_ready;
  logic [31:0] op_a, op_b, lane_out;
  logic [2:0]  op;
  logic [1:0]  lane_valid;
  logic        req_ready, ppu_valid, result_valid, error, busy;
  logic [31:0] ppu_in1, ppu_in2, result;
  logic [2:0]  ppu_op;
  logic [15:0] op_count;

  ppu_issue_ctrl #(.PPU_NUM(N), .OP_W(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_a_i(op_a), .op_b_i(op_b), .op_i(op), .flush_i(flush),
    .ppu_valid_o(ppu_valid), .ppu_in1_o(ppu_in1), .ppu_in2_o(ppu_in2), .ppu_op_o(ppu_op),
    .lane_valid_i(lane_valid), .lane_out_i(lane_out),
    .result_o(result), .result_valid_o(result_valid), .result_ready_i(result_ready),
    .error_o(error), .busy_o(busy), .op_count_o(op_count));

  // Short-timeout instance, driven separately.
  logic        t_req_valid, t_flush, t_ready;
  logic [31:0] t_lane_out;
  logic [1:0]  t_lane_valid;
  logic        t_req_ready, t_ppu_valid, t_res_vld, t_err, t_busy;
  logic [31:0] t_in1, t_in2, t_res;
  logic [2:0]  t_op;
  logic [15:0] t_cnt;

  ppu_issue_ctrl #(.PPU_NUM(N), .OP_W(3), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .req_valid_i(t_req_valid), .req_ready_o(t_req_ready),
    .op_a_i(32'h0000_3C00), .op_b_i(32'h0000_3C00), .op_i(3'd1), .flush_i(t_flush),
    .ppu_valid_o(t_ppu_valid), .ppu_in1_o(t_in1), .ppu_in2_o(t_in2), .ppu_op_o(t_op),
    .lane_valid_i(t_lane_valid), .lane_out_i(t_lane_out),
    .result_o(t_res), .result_valid_o(t_res_vld), .result_ready_i(t_ready),
    .error_o(t_err), .busy_o(t_busy), .op_count_o(t_cnt));

  int n_chk = 0;
  int n_pass = 0;

  // Transaction-level model of the main instance.
  bit          m_live = 0;
  bit          m_busy, m_pulse, m_done, m_err;
  bit [N-1:0]  m_have;
  int          m_waits;
  logic [31:0] m_res, m_in1, m_in2;
  logic [2:0]  m_op;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_busy = 0; m_pulse = 0; m_done = 0; m_err = 0; m_have = '0; m_waits = 0;
      m_res = '0; m_in1 = '0; m_in2 = '0; m_op = '0; m_cnt = '0;
    end else if (flush) begin
      m_busy = 0; m_pulse = 0; m_done = 0; m_err = 0; m_have = '0; m_waits = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_in1 = op_a; m_in2 = op_b; m_op = op; m_res = '0;
        m_busy = 1; m_pulse = 1; m_have = '0; m_waits = 0;
      end
    end else if (m_done) begin
      if (result_ready) begin
        m_cnt = m_cnt + 16'd1; m_busy = 0; m_done = 0; m_err = 0;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (lane_valid[i] && !m_have[i]) begin
          m_res[16*i +: 16] = lane_out[16*i +: 16];
          m_have[i] = 1'b1;
        end
      if (&m_have) begin
        m_done = 1; m_err = 0;
      end else if (!m_pulse && (m_waits + 1 == TO)) begin
        for (int i = 0; i < N; i++)
          if (!m_have[i]) m_res[16*i +: 16] = 16'h8000;
        m_done = 1; m_err = 1;
      end else if (!m_pulse) begin
        m_waits++;
      end
      m_pulse = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_chk++;
      if ({req_ready, ppu_valid, result_valid, error, busy, ppu_in1, ppu_in2, ppu_op, result, op_count} !==
          {(!m_busy && !flush), m_pulse, m_done, m_err, m_busy, m_in1, m_in2, m_op, m_res, m_cnt})
        $display("FAIL model t=%0t act rdy=%b pv=%b rv=%b err=%b busy=%b in1=%h in2=%h op=%h res=%h cnt=%h exp rdy=%b pv=%b rv=%b err=%b busy=%b in1=%h in2=%h op=%h res=%h cnt=%h",
                 $time, req_ready, ppu_valid, result_valid, error, busy, ppu_in1, ppu_in2, ppu_op, result, op_count,
                 (!m_busy && !flush), m_pulse, m_done, m_err, m_busy, m_in1, m_in2, m_op, m_res, m_cnt);
      else
        n_pass++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    req_valid = 1; op_a = a; op_b = b; op = o;
    step();
    req_valid = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; flush = 0; result_ready = 0; op_a = '0; op_b = '0; op = '0;
    lane_valid = '0; lane_out = '0;
    t_req_valid = 0; t_flush = 0; t_ready = 0; t_lane_valid = '0; t_lane_out = '0;
    step(); step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    rst = 0;
    step();

    // Basic op, lanes respond two cycles after the issue pulse.
    issue(32'h4000_4000, 32'h4000_4000, 3'd0);
    chk("t1_pulse", 32'(ppu_valid), 32'd1);
    chk("t1_in1", ppu_in1, 32'h4000_4000);
    step();
    chk("t1_pulse_once", 32'(ppu_valid), 32'd0);
    step();
    lane_valid = 2'b11; lane_out = 32'h5000_5000;
    chk("t1_not_yet", 32'(result_valid), 32'd0);
    step();
    lane_valid = 2'b00;
    chk("t1_rvalid", 32'(result_valid), 32'd1);
    chk("t1_result", result, 32'h5000_5000);
    chk("t1_error", 32'(error), 32'd0);
    result_ready = 1; step(); result_ready = 0;
    chk("t1_count", 32'(op_count), 32'd1);

    // Skewed lanes; a second pulse on lane0 is ignored.
    issue(32'h1, 32'h2, 3'd2);
    step();
    lane_valid = 2'b01; lane_out = 32'h0000_1111;
    step(); lane_valid = 2'b00;
    step(); lane_valid = 2'b01; lane_out = 32'h0000_FFFF;
    step(); lane_valid = 2'b00;
    step(); lane_valid = 2'b10; lane_out = 32'h2222_AAAA;
    chk("t2_not_yet", 32'(result_valid), 32'd0);
    step(); lane_valid = 2'b00;
    chk("t2_rvalid", 32'(result_valid), 32'd1);
    chk("t2_result", result, 32'h2222_1111);
    result_ready = 1; step(); result_ready = 0;

    // Zero-latency lanes.
    issue(32'h3, 32'h4, 3'd3);
    lane_valid = 2'b11; lane_out = 32'h1234_5678;
    step(); lane_valid = 2'b00;
    chk("t3_rvalid", 32'(result_valid), 32'd1);
    chk("t3_result", result, 32'h1234_5678);
    result_ready = 1; step(); result_ready = 0;
    chk("t3_count", 32'(op_count), 32'd3);

    // Timeout on the main instance (63 WAIT cycles).
    issue(32'h5, 32'h6, 3'd1);
    step(); lane_valid = 2'b01; lane_out = 32'h0000_3C00;
    step(); lane_valid = 2'b00;
    repeat (61) step();
    chk("t4_not_yet", 32'(result_valid), 32'd0);
    step();
    chk("t4_rvalid", 32'(result_valid), 32'd1);
    chk("t4_result", result, 32'h8000_3C00);
    chk("t4_error", 32'(error), 32'd1);
    result_ready = 1; step(); result_ready = 0;
    chk("t4_err_drop", 32'(error), 32'd0);

    // TIMEOUT=4 instance: plain timeout, then completion on the timeout cycle.
    t_req_valid = 1; step(); t_req_valid = 0;
    step(); t_lane_valid = 2'b01; t_lane_out = 32'h0000_3C00;
    step(); t_lane_valid = 2'b00;
    step(); step();
    chk("to4_not_yet", 32'(t_res_vld), 32'd0);
    step();
    chk("to4_rvalid", 32'(t_res_vld), 32'd1);
    chk("to4_result", t_res, 32'h8000_3C00);
    chk("to4_error", 32'(t_err), 32'd1);
    t_ready = 1; step(); t_ready = 0;
    chk("to4_count", 32'(t_cnt), 32'd1);
    t_req_valid = 1; step(); t_req_valid = 0;
    step(); t_lane_valid = 2'b01; t_lane_out = 32'h0000_AAAA;
    step(); t_lane_valid = 2'b00;
    step();
    step(); t_lane_valid = 2'b10; t_lane_out = 32'h5555_FFFF;
    step(); t_lane_valid = 2'b00;
    chk("to4_tie_rvalid", 32'(t_res_vld), 32'd1);
    chk("to4_tie_result", t_res, 32'h5555_AAAA);
    chk("to4_tie_error", 32'(t_err), 32'd0);
    t_ready = 1; step(); t_ready = 0;

    // Flush during WAIT, late lane results ignored, then a normal op.
    issue(32'h7, 32'h8, 3'd4);
    step();
    flush = 1; #1;
    chk("t6_rdy_flush", 32'(req_ready), 32'd0);
    step(); flush = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    lane_valid = 2'b11; lane_out = 32'hDEAD_BEEF;
    step(); lane_valid = 2'b00;
    step();
    chk("t6_no_rvalid", 32'(result_valid), 32'd0);
    chk("t6_count", 32'(op_count), 32'd4);
    issue(32'h0000_0001, 32'h0000_0002, 3'd5);
    chk("t6_reissue", ppu_in1, 32'h0000_0001);
    chk("t6_op", 32'(ppu_op), 32'd5);
    lane_valid = 2'b11; lane_out = 32'h0003_0003;
    step(); lane_valid = 2'b00;
    result_ready = 1; step(); result_ready = 0;
    chk("t6_count2", 32'(op_count), 32'd5);

    // Flush in DONE together with result_ready: not counted.
    issue(32'h9, 32'hA, 3'd6);
    lane_valid = 2'b11; lane_out = 32'h0101_0202;
    step(); lane_valid = 2'b00;
    flush = 1; result_ready = 1;
    step(); flush = 0; result_ready = 0;
    chk("t7_count", 32'(op_count), 32'd5);
    chk("t7_busy", 32'(busy), 32'd0);

    // Backpressure with a pending request.
    issue(32'h0A0A_0A0A, 32'h0, 3'd0);
    lane_valid = 2'b11; lane_out = 32'h7777_8888;
    step(); lane_valid = 2'b00;
    req_valid = 1; op_a = 32'h0B0B_0B0B;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t8_rdy_low", 32'(req_ready), 32'd0);
      chk("t8_hold", result, 32'h7777_8888);
    end
    result_ready = 1; step(); result_ready = 0;
    chk("t8_idle", 32'(busy), 32'd0);
    chk("t8_rdy", 32'(req_ready), 32'd1);
    step(); req_valid = 0;
    chk("t8_accept", ppu_in1, 32'h0B0B_0B0B);
    lane_valid = 2'b11; lane_out = 32'h0;
    step(); lane_valid = 2'b00;
    result_ready = 1; step(); result_ready = 0;
    chk("t8_count", 32'(op_count), 32'd7);

    // Back-to-back ops with result_ready held high.
    result_ready = 1;
    for (int k = 0; k < 20; k++) begin
      issue(32'(k), 32'(k + 1), 3'(k));
      lane_valid = 2'b11; lane_out = 32'(k * 32'h0001_0001);
      step(); lane_valid = 2'b00;
      step();
    end
    result_ready = 0;
    chk("t9_count", 32'(op_count), 32'd27);

    // Reset in WAIT.
    issue(32'hCAFE_F00D, 32'h1, 3'd7);
    step();
    rst = 1; step(); rst = 0;
    chk("t10_count", 32'(op_count), 32'd0);
    chk("t10_busy", 32'(busy), 32'd0);
    chk("t10_in1", ppu_in1, 32'd0);
    chk("t10_result", result, 32'd0);
    chk("t10_rdy", 32'(req_ready), 32'd1);
    step();

    m_live = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ppu_issue_ctrl.md
Name: ppu_issue_ctrl

Overview:
- Sequencing controller between the EX stage and the PPU lane array (PPU_NUM posit lanes, each LANE_W bits).
- Accepts one posit operation per request and broadcasts it to all lanes with a single-cycle valid pulse.
- Collects per-lane valid/result independently, since lanes may finish on different cycles, and presents one merged 32-bit result with a valid/ready handshake.
- Adds a per-operation timeout, a flush, and a wrapping completed-op counter.

Parameters:
PPU_NUM, 2, number of PPU lanes; must divide 32 (1, 2 or 4)
LANE_W, 32/PPU_NUM, bits per lane slice
OP_W, 3, PPU operator width (PPU_OP_WIDTH)
TIMEOUT, 63, maximum WAIT-state cycles before the op is aborted; 1..255

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  EX requests a PPU op
req_ready_o  out  1  controller accepts request this cycle
op_a_i  in  32  packed lane operand A (lane i = bits [LANE_W*i +: LANE_W])
op_b_i  in  32  packed lane operand B
op_i  in  OP_W  PPU operator
flush_i  in  1  abort any op in flight
ppu_valid_o  out  1  one-cycle issue pulse to all lanes
ppu_in1_o  out  32  registered operand A to lanes
ppu_in2_o  out  32  registered operand B to lanes
ppu_op_o  out  OP_W  registered operator to lanes
lane_valid_i  in  PPU_NUM  per-lane result valid
lane_out_i  in  32  packed lane results
result_o  out  32  merged result
result_valid_o  out  1  result available
result_ready_i  in  1  EX consumes result
error_o  out  1  current result came from a timeout
busy_o  out  1  state != IDLE
op_count_o  out  16  completed (non-flushed) ops, wraps at 0xFFFF->0

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high; everything samples on posedge clk.
- Values after reset: state=IDLE, all outputs 0 except req_ready_o=1, lane mask=0, timer=0, op_count_o=0.
- req_ready_o = (state==IDLE) & ~flush_i. This is the only combinational path from an input to an output.

FSM states: IDLE, ISSUE, WAIT, DONE.

- IDLE:
  - On req_valid_i & req_ready_o, register op_a_i, op_b_i and op_i into ppu_in1_o, ppu_in2_o and ppu_op_o, then go to ISSUE.
  - The operand registers hold stable until the next accept.
- ISSUE (exactly one cycle):
  - ppu_valid_o=1, lane mask cleared, timer cleared; go to WAIT.
  - lane_valid_i is also sampled in this cycle, to support zero-latency lanes.
- WAIT:
  - For each lane i with lane_valid_i[i]=1 and mask[i]=0: capture lane_out_i slice i into result slice i and set mask[i]. Later pulses on an already-set lane are ignored.
  - Timer increments by 1 per WAIT cycle.
  - Go to DONE when (mask | lane_valid_i) is all ones, with error=0.
  - Otherwise, when timer == TIMEOUT-1, go to DONE with error=1. Every lane whose mask bit is still 0 gets the posit NaR pattern (MSB 1, rest 0) in its slice.
  - If completion and timeout occur in the same cycle, completion wins and error=0.
- DONE:
  - result_valid_o=1; result_o and error_o are held stable.
  - On result_ready_i: op_count_o+=1 (wrapping), go to IDLE.
  - The next request cannot be accepted in that same cycle; the earliest accept is the following cycle.
- Latency: an accept at cycle t gives ppu_valid_o at t+1. For a lane latency of L cycles after the issue pulse, the earliest result_valid_o is at t+2+L.
- flush_i, any state:
  - Next state is IDLE.
  - ppu_valid_o, result_valid_o and error_o drop the next cycle; mask and timer are cleared; op_count_o is unchanged.
  - A flush during DONE together with result_ready_i counts as a flush; the op is not counted.
- Reset mid-operation: identical to flush, but op_count_o also returns to 0.
- Lane results returning while in IDLE or DONE are ignored.

Test Plan:
- PPU_NUM=2: accept at t with op_a=0x40004000, op_b=0x40004000, op=ADD; both lanes return valid at t+3 with 0x50005000 -> ppu_valid_o high only at t+1, result_o=0x50005000 and result_valid_o=1 from t+4, error_o=0; ready -> op_count_o=1.
- Skewed lanes: lane0 valid at issue+1 with 0x1111, lane1 valid at issue+5 with 0x2222, and lane0 pulses again with 0xFFFF -> result_o=0x22221111, valid asserted the cycle after lane1's valid.
- TIMEOUT=4, lane1 never responds, lane0 returns 0x3C00 -> after 4 WAIT cycles result_o=0x80003C00, error_o=1.
- Flush during WAIT, then a late lane valid -> busy_o=0 next cycle, result_valid_o never asserts, op_count_o unchanged; the next request is accepted normally.
- Backpressure: hold result_ready_i=0 for 10 cycles while req_valid_i=1 -> req_ready_o=0 throughout and result_o stable; ready -> IDLE; accept on the following cycle.
- Preload op_count_o=0xFFFF via 65535 completions, one more -> 0x0000; assert rst in WAIT -> all outputs at reset values the next cycle.
